// File: rtl/pattern_detector.sv
// Serial bit-pattern detector: a KMP transition table built from PATTERN at
// elaboration drives a prefix-length state register, a match pulse and a counter.
module pattern_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8,
    localparam int                SW      = $clog2(PAT_LEN + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x_in,
    input  logic             x_valid,
    output logic             y_out,
    output logic [CNT_W-1:0] match_count,
    output logic [SW-1:0]    state_out
);

    localparam int ENTRY_W = SW + 1;
    localparam int TBL_W   = 2 * PAT_LEN * ENTRY_W;
    localparam int ENTRIES = 2 ** (SW + 1);

    // Longest proper prefix of PATTERN that is also a suffix of it.
    function automatic int border();
        int   best;
        logic eq;
        best = 0;
        for (int k = 1; k < PAT_LEN; k++) begin
            eq = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (PATTERN[PAT_LEN-1-j] != PATTERN[k-1-j]) eq = 1'b0;
            end
            if (eq) best = k;
        end
        return best;
    endfunction

    // Entry for (s, b) at index s*2+b holds {match, next_state}.
    function automatic logic [TBL_W-1:0] build_table();
        logic [TBL_W-1:0] tbl;
        logic [SW-1:0]    nxt;
        logic             eq;
        logic             tb;
        logic             hit;
        int               best;
        tbl = '0;
        for (int s = 0; s < PAT_LEN; s++) begin
            for (int b = 0; b < 2; b++) begin
                best = 0;
                for (int k = 1; k <= s + 1; k++) begin
                    eq = 1'b1;
                    for (int j = 0; j < k; j++) begin
                        tb = (s + 1 - k + j < s) ? PATTERN[PAT_LEN-1-(s+1-k+j)] : (b != 0);
                        if (tb != PATTERN[PAT_LEN-1-j]) eq = 1'b0;
                    end
                    if (eq) best = k;
                end
                hit = (best == PAT_LEN);
                if (hit) nxt = (OVERLAP != 0) ? SW'(border()) : '0;
                else     nxt = SW'(best);
                tbl[(s*2+b)*ENTRY_W +: ENTRY_W] = {hit, nxt};
            end
        end
        return tbl;
    endfunction

    localparam logic [TBL_W-1:0] TABLE = build_table();

    logic [ENTRY_W-1:0] tbl_rom [ENTRIES];
    logic [SW:0]        tbl_idx;
    logic [ENTRY_W-1:0] entry;
    logic [SW-1:0]      state;

    // Unreachable indices (state >= PAT_LEN) are tied to zero.
    for (genvar g = 0; g < ENTRIES; g++) begin : g_rom
        if (g < 2 * PAT_LEN) begin : g_used
            assign tbl_rom[g] = TABLE[g*ENTRY_W +: ENTRY_W];
        end else begin : g_unused
            assign tbl_rom[g] = '0;
        end
    end

    assign tbl_idx   = {state, x_in};
    assign entry     = tbl_rom[tbl_idx];
    assign state_out = state;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= '0;
            y_out       <= 1'b0;
            match_count <= '0;
        end else if (x_valid) begin
            state <= entry[SW-1:0];
            y_out <= entry[SW];
            if (entry[SW] && (match_count != {CNT_W{1'b1}})) begin
                match_count <= match_count + 1'b1;
            end
        end else begin
            y_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pattern_detector.sv
// Bench for pattern_detector: six parameterisations share one input stream and
// are compared against a history-string reference model.
module tb_pattern_detector;

    localparam int N = 6;
    localparam int M_LEN [N] = '{4, 4, 4, 4, 4, 2};
    localparam int M_PAT [N] = '{11, 11, 10, 10, 11, 3};
    localparam int M_OV  [N] = '{1, 0, 1, 0, 1, 1};
    localparam int M_CW  [N] = '{8, 8, 8, 8, 2, 8};

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic x_in = 1'b0;
    logic x_valid = 1'b0;

    logic       y0, y1, y2, y3, y4, y5;
    logic [7:0] c0, c1, c2, c3, c5;
    logic [1:0] c4;
    logic [2:0] s0, s1, s2, s3, s4;
    logic [1:0] s5;

    logic        y_a [N];
    logic [15:0] c_a [N];
    logic [15:0] s_a [N];

    int checks = 0;
    int failures = 0;

    // Reference model state: recent accepted bits and how many are meaningful.
    int hist [N];
    int hlen [N];
    logic exp_y [N];
    int exp_cnt [N];

    always #5 clock = ~clock;

    pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) d0 (
        .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid),
        .y_out(y0), .match_count(c0), .state_out(s0));
    pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) d1 (
        .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid),
        .y_out(y1), .match_count(c1), .state_out(s1));
    pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1), .CNT_W(8)) d2 (
        .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid),
        .y_out(y2), .match_count(c2), .state_out(s2));
    pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(0), .CNT_W(8)) d3 (
        .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid),
        .y_out(y3), .match_count(c3), .state_out(s3));
    pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) d4 (
        .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid),
        .y_out(y4), .match_count(c4), .state_out(s4));
    pattern_detector #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(8)) d5 (
        .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid),
        .y_out(y5), .match_count(c5), .state_out(s5));

    always_comb begin
        y_a[0] = y0; y_a[1] = y1; y_a[2] = y2; y_a[3] = y3; y_a[4] = y4; y_a[5] = y5;
        c_a[0] = 16'(c0); c_a[1] = 16'(c1); c_a[2] = 16'(c2);
        c_a[3] = 16'(c3); c_a[4] = 16'(c4); c_a[5] = 16'(c5);
        s_a[0] = 16'(s0); s_a[1] = 16'(s1); s_a[2] = 16'(s2);
        s_a[3] = 16'(s3); s_a[4] = 16'(s4); s_a[5] = 16'(s5);
    end

    function automatic int mask(input int k);
        return (1 << k) - 1;
    endfunction

    // Longest k < PAT_LEN such that the last k accepted bits spell the first k pattern bits.
    function automatic int model_state(input int i);
        int best = 0;
        for (int k = 1; k < M_LEN[i]; k++) begin
            if (k <= hlen[i] &&
                (hist[i] & mask(k)) == ((M_PAT[i] >> (M_LEN[i] - k)) & mask(k)))
                best = k;
        end
        return best;
    endfunction

    // Drive one clock of inputs, then advance the model; outputs settle #1 later.
    task automatic step(input logic rst_n, input logic v, input logic b);
        @(negedge clock);
        reset = rst_n;
        x_valid = v;
        x_in = b;
        @(posedge clock);
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                hist[i] = 0; hlen[i] = 0; exp_y[i] = 1'b0; exp_cnt[i] = 0;
            end else if (v) begin
                hist[i] = ((hist[i] << 1) | int'(b)) & 16'hFFFF;
                if (hlen[i] < 16) hlen[i]++;
                exp_y[i] = 1'b0;
                if (hlen[i] >= M_LEN[i] && (hist[i] & mask(M_LEN[i])) == M_PAT[i]) begin
                    exp_y[i] = 1'b1;
                    if (exp_cnt[i] < mask(M_CW[i])) exp_cnt[i]++;
                    if (M_OV[i] == 0) hlen[i] = 0;
                end
            end else begin
                exp_y[i] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) step(1'b1, 1'b1, bits[k]);
    endtask

    task automatic test_reset();
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (y_a[i] !== 1'b0 || c_a[i] !== 16'd0 || s_a[i] !== 16'd0) begin
                failures++;
                $display("FAIL reset dut%0d: y=%0b cnt=%0d state=%0d, required 0/0/0",
                         i, y_a[i], c_a[i], s_a[i]);
            end
        end
    endtask

    task automatic test_overlap_stream();
        logic [6:0] bits = 7'b1011011;
        int pulses0 = 0;
        step(1'b0, 1'b0, 1'b0);
        for (int k = 6; k >= 0; k--) begin
            step(1'b1, 1'b1, bits[k]);
            if (y_a[0]) pulses0++;
            checks++;
            if (y_a[0] !== ((k == 3) || (k == 0))) begin
                failures++;
                $display("FAIL overlap_pulse bit%0d: y=%0b, required %0b", 7 - k, y_a[0],
                         (k == 3) || (k == 0));
            end
        end
        checks++;
        if (c_a[0] !== 16'd2 || s_a[0] !== 16'd1 || pulses0 != 2) begin
            failures++;
            $display("FAIL overlap_end: cnt=%0d state=%0d pulses=%0d, required 2/1/2",
                     c_a[0], s_a[0], pulses0);
        end
        checks++;
        if (c_a[1] !== 16'd1) begin
            failures++;
            $display("FAIL nonoverlap_count: cnt=%0d, required 1", c_a[1]);
        end
    endtask

    task automatic test_alt_pattern();
        step(1'b0, 1'b0, 1'b0);
        send_bits(16'b101010, 6);
        checks++;
        if (c_a[2] !== 16'd2 || y_a[2] !== 1'b1) begin
            failures++;
            $display("FAIL alt_overlap: cnt=%0d y=%0b, required 2/1", c_a[2], y_a[2]);
        end
        checks++;
        if (c_a[3] !== 16'd1 || y_a[3] !== 1'b0) begin
            failures++;
            $display("FAIL alt_nonoverlap: cnt=%0d y=%0b, required 1/0", c_a[3], y_a[3]);
        end
    endtask

    task automatic test_gap();
        step(1'b0, 1'b0, 1'b0);
        send_bits(16'b101, 3);
        for (int g = 0; g < 3; g++) begin
            step(1'b1, 1'b0, 1'bx);
            checks++;
            if (s_a[0] !== 16'd3 || y_a[0] !== 1'b0) begin
                failures++;
                $display("FAIL gap_hold cycle%0d: state=%0d y=%0b, required 3/0", g, s_a[0], y_a[0]);
            end
        end
        step(1'b1, 1'b1, 1'b1);
        checks++;
        if (y_a[0] !== 1'b1 || c_a[0] !== 16'd1) begin
            failures++;
            $display("FAIL gap_match: y=%0b cnt=%0d, required 1/1", y_a[0], c_a[0]);
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (y_a[0] !== 1'b0) begin
            failures++;
            $display("FAIL gap_pulse_width: y=%0b, required 0", y_a[0]);
        end
    endtask

    task automatic test_mid_reset();
        step(1'b0, 1'b0, 1'b0);
        send_bits(16'b101, 3);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        checks++;
        if (y_a[0] !== 1'b0 || s_a[0] !== 16'd1 || c_a[0] !== 16'd0) begin
            failures++;
            $display("FAIL mid_reset: y=%0b state=%0d cnt=%0d, required 0/1/0",
                     y_a[0], s_a[0], c_a[0]);
        end
    endtask

    task automatic test_saturate();
        int exp_seq [5] = '{1, 2, 3, 3, 3};
        int m = 0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        for (int r = 0; r < 5; r++) begin
            send_bits(16'b011, 3);
            if (y_a[4]) begin
                checks++;
                if (c_a[4] !== 16'(exp_seq[m])) begin
                    failures++;
                    $display("FAIL saturate match%0d: cnt=%0d, required %0d", m, c_a[4], exp_seq[m]);
                end
                m++;
            end
        end
        checks++;
        if (m != 5) begin
            failures++;
            $display("FAIL saturate_pulses: pulses=%0d, required 5", m);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 1'b1, 1'b1);
            checks++;
            if (y_a[5] !== (k >= 2)) begin
                failures++;
                $display("FAIL back_to_back bit%0d: y=%0b, required %0b", k, y_a[5], k >= 2);
            end
        end
        checks++;
        if (c_a[5] !== 16'd4 || s_a[5] !== 16'd1) begin
            failures++;
            $display("FAIL back_to_back_end: cnt=%0d state=%0d, required 4/1", c_a[5], s_a[5]);
        end
    endtask

    task automatic test_random();
        logic r;
        logic v;
        step(1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 199) != 0);
            v = ($urandom_range(0, 3) != 0);
            step(r, v, 1'($urandom_range(0, 1)));
            for (int i = 0; i < N; i++) begin
                checks++;
                if (y_a[i] !== exp_y[i] || c_a[i] !== 16'(exp_cnt[i]) ||
                    s_a[i] !== 16'(model_state(i))) begin
                    failures++;
                    $display("FAIL random n%0d dut%0d: y=%0b cnt=%0d state=%0d, required %0b/%0d/%0d",
                             n, i, y_a[i], c_a[i], s_a[i], exp_y[i], exp_cnt[i], model_state(i));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            hist[i] = 0; hlen[i] = 0; exp_y[i] = 1'b0; exp_cnt[i] = 0;
        end
        test_reset();
        test_overlap_stream();
        test_alt_pattern();
        test_gap();
        test_mid_reset();
        test_saturate();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
